uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive half of the board-side UART link for the CPU's serial port. It turns an asynchronous 8N1 line (optionally 8E1) into bytes and buffers them in a small FIFO behind a valid/ready handshake. It sits in the FPGA top level, on the `clk_50mhz` domain, so board logic can capture the CPU's transmit line `uart0_txd_out` without a host PC.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clocks per bit. 50 MHz / 115200. Must be ≥ 4.
- `FIFO_DEPTH`, default 4: number of buffered bytes. Power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock. All state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  serial input. Idle high. Asynchronous to `clk`.
- `rx_data`  out  8  byte at the FIFO head. Valid only while `rx_valid`.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte.
- `frame_err`  out  1  one-cycle pulse: the stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped because the FIFO was full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is not compiled in.
- `busy`  out  1  receiver state is not IDLE.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- **IDLE:** on `rxs` == 0, load the bit counter with `CLKS_PER_BIT/2 - 1` (integer divide) and go to START.
- **START:** at counter == 0, sample `rxs`.
  - Sample 1 (glitch): return to IDLE. No flag.
  - Sample 0: go to DATA, bit index = 0, counter = `CLKS_PER_BIT - 1`.
- **DATA:** at each counter expiry, sample `rxs` into the shift register, LSB first, then reload the counter. After index 7, go to PARITY if compiled in, otherwise STOP.
- **STOP:** at counter expiry, sample `rxs`.
  - Sample 1: byte complete. Push it, then go to IDLE.
  - Sample 0: pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK:** wait until `rxs` == 1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **FIFO:** read and write pointers are `log2(FIFO_DEPTH)+1` bits wide so they wrap naturally.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Pop: occurs when `rx_valid && rx_ready`.
  - Push into a full FIFO: the byte is dropped, `overrun` pulses, FIFO contents are unchanged.
  - Simultaneous push and pop on a full FIFO: the pop is honoured first and the push is accepted. No `overrun`.
  - Simultaneous push and pop on an empty FIFO: impossible, because `rx_valid` is 0.
- **Output rules:** `rx_data` is the head entry, read combinationally from the FIFO array. It holds stable while `rx_valid && !rx_ready`.
- **Reset mid-frame:** the FSM goes to IDLE, the FIFO empties, and all pulses clear. A partially received byte is lost. After release, the next falling edge starts a new frame, even if it falls in the middle of an old frame.

## Timing
- Reset values:
  - `rx_valid`, `frame_err`, `overrun`, `parity_err`, `busy` = 0.
  - `rx_data` = 8'h00 (the array clears on reset).
  - Both synchronizer flops = 1.
- `rxd` fall to the START transition: 3 clocks. Two synchronizer stages, then the IDLE detect.
- The sample point is mid-bit. The start bit is sampled `CLKS_PER_BIT/2` clocks after START entry. Each later bit is sampled every `CLKS_PER_BIT` clocks after that.
- Stop sample at cycle N: the push happens at the end of N, and `rx_valid` is 1 in cycle N+1. `frame_err`, `overrun` and `parity_err` are high for cycle N+1 only.
- Pop at the end of cycle M: the next entry (or `rx_valid` = 0) appears in M+1.
- `busy` rises with START entry. It falls on the IDLE return, including the glitch and BREAK-exit paths.
- Back-to-back frames: the receiver returns to IDLE half a bit before the stop bit ends. The next start bit is detected with no gap.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frames are 8E1. PARITY samples one extra bit with a full-bit counter reload.
  - A mismatch (XOR of data and parity ≠ 0) pulses `parity_err` in the cycle after the stop sample.
  - The byte is still pushed if the stop bit is valid.
  - A frame error takes precedence: the byte is discarded and `parity_err` is not asserted.
- **Undefined:** frames are 8N1. The PARITY state is absent and `parity_err` is tied to 0.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=8, send 8'hA5 with `rx_ready`=0.
  - `rx_valid` rises and `rx_data`=8'hA5.
  - Raising `rx_ready` for 1 cycle drops `rx_valid`.
- **Glitch rejection:** drive a low pulse of 3 clocks on an idle line (`CLKS_PER_BIT`=8).
  - No byte, no flags.
  - `busy` returns to 0 and a following 8'h3C is received correctly.
- **Overrun:** send 8'h01..8'h05 back-to-back with `rx_ready`=0 (`FIFO_DEPTH`=4).
  - `overrun` pulses once, on byte 5.
  - Pops yield 8'h01, 8'h02, 8'h03, 8'h04.
- **Framing error and break:** send 8'h55 with the stop bit low, then hold the line low for 40 bit-times.
  - Exactly one `frame_err` pulse, no push.
  - `busy` stays 1 until the line rises.
- **Reset mid-frame:** assert `rst_n` low during DATA bit 4, then release.
  - All outputs return to their reset values.
  - A following 8'hC3 is received intact.
- **Parity (with `UART_RX_PARITY_EN`):**
  - 8'h07 with a parity bit of 1: accepted, no error.
  - The same byte with a parity bit of 0: pushed, and `parity_err` pulses once.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver with a byte FIFO behind valid/ready.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic          rxs, cnt_zero, push, pop, full, push_ok;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d, parity_err_q, parity_err_d;
`endif

    assign rxs      = sync_q[1];
    assign cnt_zero = (cnt_q == '0);
    assign busy     = (state_q != IDLE);

    always_comb begin
        sync_d      = {sync_q[0], rxd};
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    cnt_d   = FULL_RELOAD;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = FULL_RELOAD;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_d   = rxs;
                    cnt_d   = FULL_RELOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    push    = 1'b1;
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = ^{shift_q, par_q};
`endif
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        rx_valid  = (rd_ptr_q != wr_ptr_q);
        full      = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
        pop       = rx_valid && rx_ready;
        push_ok   = push && (!full || pop);
        overrun_d = push && full && !pop;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        mem_d     = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        end
    end

    assign rx_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at 8 clocks per bit, depth 4.
module tb_uart_rx_fifo;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err, busy;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        tick(CPB);
`endif
        rxd = stop_bit;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic pop_check(input logic [7:0] exp, input string name);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp) begin
            errors++;
            $display("FAIL %s: valid=%b data=%h, want valid=1 data=%h", name, rx_valid, rx_data, exp);
        end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic expect_empty(input string name);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: rx_valid=%b, want 0", name, rx_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({rx_valid, frame_err, overrun, parity_err, busy} !== 5'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid/fe/ov/pe/busy=%b data=%h, want 00000 data=00",
                     {rx_valid, frame_err, overrun, parity_err, busy}, rx_data);
        end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b valid=%b, want 0 0", busy, rx_valid);
        end
    endtask

    task automatic test_single_byte();
        send_frame(8'hA5, 1'b1);
        tick(5);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || busy !== 1'b0 || fe_cnt !== 0) begin
            errors++;
            $display("FAIL single_byte: valid=%b data=%h busy=%b fe=%0d, want 1 a5 0 0",
                     rx_valid, rx_data, busy, fe_cnt);
        end
        pop_check(8'hA5, "single_byte_pop");
        expect_empty("single_byte_empty");
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_rise: busy=%b, want 1", busy);
        end
        tick(20);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_reject: busy=%b valid=%b fe=%0d ov=%0d, want 0 0 0 0",
                     busy, rx_valid, fe_cnt, ov_cnt);
        end
        send_frame(8'h3C, 1'b1);
        tick(2);
        pop_check(8'h3C, "glitch_next_byte");
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
        checks++;
        if (ov_cnt - ov0 !== 0) begin
            errors++;
            $display("FAIL overrun_early: pulses=%0d, want 0", ov_cnt - ov0);
        end
        send_frame(8'h05, 1'b1);
        tick(2);
        checks++;
        if (ov_cnt - ov0 !== 1) begin
            errors++;
            $display("FAIL overrun_byte5: pulses=%0d, want 1", ov_cnt - ov0);
        end
        for (int b = 1; b <= 4; b++) pop_check(8'(b), "overrun_pop");
        expect_empty("overrun_drained");
    endtask

    task automatic test_frame_break();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        rxd = 1'b0;
        tick(40 * CPB);
        checks++;
        if (busy !== 1'b1 || fe_cnt - fe0 !== 1 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL break_hold: busy=%b fe=%0d valid=%b, want 1 1 0", busy, fe_cnt - fe0, rx_valid);
        end
        rxd = 1'b1;
        tick(5);
        checks++;
        if (busy !== 1'b0 || fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL break_exit: busy=%b fe=%0d, want 0 1", busy, fe_cnt - fe0);
        end
        expect_empty("break_no_push");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        send_frame(8'h11, 1'b1);
        d = 8'hC3;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        rxd = d[4];
        tick(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_valid, frame_err, overrun, parity_err, busy} !== 5'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset: valid/fe/ov/pe/busy=%b data=%h, want 00000 data=00",
                     {rx_valid, frame_err, overrun, parity_err, busy}, rx_data);
        end
        tick(2);
        rxd = 1'b1;
        rst_n = 1'b1;
        tick(5);
        send_frame(8'hC3, 1'b1);
        tick(2);
        pop_check(8'hC3, "midframe_next_byte");
        expect_empty("midframe_empty");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0;
        pe0 = pe_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        tick(2);
        checks++;
        if (pe_cnt - pe0 !== 0) begin
            errors++;
            $display("FAIL parity_good: pulses=%0d, want 0", pe_cnt - pe0);
        end
        pop_check(8'h07, "parity_good_pop");
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        tick(2);
        checks++;
        if (pe_cnt - pe0 !== 1) begin
            errors++;
            $display("FAIL parity_bad: pulses=%0d, want 1", pe_cnt - pe0);
        end
        pop_check(8'h07, "parity_bad_pop");
    endtask
`else
    task automatic test_parity();
        checks++;
        if (pe_cnt !== 0) begin
            errors++;
            $display("FAIL parity_tied_low: pulses=%0d, want 0", pe_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_overrun();
        test_frame_break();
        test_reset_mid_frame();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
